seq_pattern_scan_ctrl: RTL and testbench



---
 rtl/seq_scan_pkg.sv | 23 ++
 rtl/seq_pattern_scan_ctrl_core.sv | 49 ++++
 rtl/seq_pattern_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seq_pattern_scan_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the serial pattern scan controller.
//   state_t   : controller states
//   DEF_*     : default parameter values
//   clamp_len : folds a requested pattern length into 1..maxlen
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_MAXLEN = 8;
  localparam int DEF_LW     = 4;
  localparam int DEF_CW     = 8;

  function automatic int clamp_len(input int len, input int maxlen);
    if (len < 1)           return 1;
    else if (len > maxlen) return maxlen;
    else                   return len;
  endfunction

endpackage

// File: rtl/seq_pattern_scan_ctrl_core.sv
// pattern_match_core: history shift register, fill counter and masked compare.
//   clk, rst    : clock, synchronous active-high reset
//   bit_valid   : shift bit_in into the history this cycle
//   bit_in      : serial data bit
//   clear       : empty history and fill (new scan)
//   clear_fill  : restart fill on this bit (non-overlapping mode after a hit)
//   len         : active pattern length, already clamped to 1..MAXLEN
//   pattern     : pattern, bit [len-1] received first
//   hit         : combinational; the bit being shifted in completes a match
module pattern_match_core #(
  parameter int MAXLEN = 8,
  parameter int LW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              clear,
  input  logic              clear_fill,
  input  logic [LW-1:0]     len,
  input  logic [MAXLEN-1:0] pattern,
  output logic              hit
);

  logic [MAXLEN-1:0] hist_q, hist_nx, mask;
  logic [LW-1:0]     fill_q, fill_nx;

  // hit is evaluated against the post-shift history and fill so the match
  // can be registered on the same edge that accepts the completing bit.
  always_comb begin
    hist_nx = {hist_q[MAXLEN-2:0], bit_in};
    fill_nx = (fill_q >= LW'(MAXLEN)) ? LW'(MAXLEN) : fill_q + LW'(1);
    for (int i = 0; i < MAXLEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = bit_valid && (fill_nx >= len) && (((hist_nx ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (bit_valid) begin
      hist_q <= hist_nx;
      fill_q <= clear_fill ? '0 : fill_nx;
    end
  end

endmodule

// File: rtl/seq_pattern_scan_ctrl.sv
// Programmable serial bit-pattern scan controller.
//   clk, rst                  : clock, synchronous active-high reset
//   cfg_valid / cfg_ready     : config handshake (ready only in IDLE)
//   cfg_pattern, cfg_len      : pattern and length (len 0 -> 1, >MAXLEN -> MAXLEN)
//   cfg_max_matches           : stop after this many matches, 0 = unlimited
//   cfg_overlap               : 1 = overlapping matches allowed
//   start                     : arm a scan (IDLE only)
//   abort                     : abandon the scan (SCAN only)
//   bit_valid, bit_in         : qualified serial stream
//   busy                      : scanning
//   match                     : one-cycle pulse, one cycle after the completing bit
//   match_count               : saturating match count since last start
//   done                      : one-cycle pulse when the match limit is reached
module seq_pattern_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int MAXLEN = DEF_MAXLEN,
  parameter int LW     = DEF_LW,
  parameter int CW     = DEF_CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic [CW-1:0]     cfg_max_matches,
  input  logic              cfg_overlap,
  input  logic              start,
  input  logic              abort,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              busy,
  output logic              match,
  output logic [CW-1:0]     match_count,
  output logic              done
);

  // state | meaning
  // IDLE  | accepts config and start, stream ignored
  // SCAN  | shifting bits, reporting matches
  // DONE  | match limit reached, one-cycle done pulse

  state_t            state_q, state_nx;
  logic [MAXLEN-1:0] pat_q;
  logic [LW-1:0]     len_q;
  logic [CW-1:0]     max_q, cnt_q, cnt_inc;
  logic              ovl_q, match_q;
  logic              core_valid, core_clear, core_hit, hit_ok, clear_fill;

  assign core_valid = (state_q == SCAN) && bit_valid;
  assign core_clear = (state_q == IDLE) && start;
  // abort wins over a hit arriving in the same cycle
  assign hit_ok     = core_hit && !abort;
  assign clear_fill = hit_ok && !ovl_q;
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  pattern_match_core #(
    .MAXLEN(MAXLEN),
    .LW    (LW)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (core_valid),
    .bit_in    (bit_in),
    .clear     (core_clear),
    .clear_fill(clear_fill),
    .len       (len_q),
    .pattern   (pat_q),
    .hit       (core_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: if (start) state_nx = SCAN;
      SCAN: begin
        if (abort)
          state_nx = IDLE;
        else if (hit_ok && (max_q != '0) && (cnt_inc == max_q))
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= '0;
      len_q   <= LW'(MAXLEN);
      max_q   <= '0;
      ovl_q   <= 1'b1;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if ((state_q == IDLE) && cfg_valid) begin
        pat_q <= cfg_pattern;
        len_q <= LW'(clamp_len(int'(cfg_len), MAXLEN));
        max_q <= cfg_max_matches;
        ovl_q <= cfg_overlap;
      end
      if (core_clear) cnt_q <= '0;
      if (hit_ok) begin
        match_q <= 1'b1;
        cnt_q   <= cnt_inc;
      end
    end
  end

  assign cfg_ready   = (state_q == IDLE);
  assign busy        = (state_q == SCAN);
  assign done        = (state_q == DONE);
  assign match       = match_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_pattern_scan_ctrl.sv
module tb_seq_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic [7:0] cfg_max_matches = '0;
  logic       cfg_overlap = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       busy;
  logic       match;
  logic [7:0] match_count;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  seq_pattern_scan_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_pattern    (cfg_pattern),
    .cfg_len        (cfg_len),
    .cfg_max_matches(cfg_max_matches),
    .cfg_overlap    (cfg_overlap),
    .start          (start),
    .abort          (abort),
    .bit_valid      (bit_valid),
    .bit_in         (bit_in),
    .busy           (busy),
    .match          (match),
    .match_count    (match_count),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                           input logic [7:0] mx, input logic ovl);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len;
    cfg_max_matches = mx; cfg_overlap = ovl;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feed n bits MSB first; record which bits were followed by a match/done pulse.
  task automatic feed(input logic [15:0] bits, input int n,
                      output logic [15:0] pmask, output logic [15:0] dmask);
    pmask = '0; dmask = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bit_valid = 1'b1; bit_in = bits[i];
      tick();
      pmask[i] = match;
      dmask[i] = done;
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_cmp++; if ({cfg_ready, busy, match, done} !== 4'b1000) begin
      n_err++; $display("FAIL reset_flags got=%b exp=1000", {cfg_ready, busy, match, done}); end
    n_cmp++; if (match_count !== 8'd0) begin
      n_err++; $display("FAIL reset_count got=%0d exp=0", match_count); end
  endtask

  // Reset config is pattern 0, len 8, unlimited, overlap: nine zeros hit after bits 8 and 9.
  task automatic test_reset_config();
    logic [15:0] pm, dm;
    arm();
    feed(16'h0000, 9, pm, dm);
    n_cmp++; if (pm[8:0] !== 9'b000000011) begin
      n_err++; $display("FAIL reset_cfg_pulses got=%b exp=000000011", pm[8:0]); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] pm, dm;
    configure(8'b00101011, 4'd6, 8'd0, 1'b1);
    arm();
    n_cmp++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_armed busy=%b ready=%b exp busy=1 ready=0", busy, cfg_ready); end
    feed(16'b101011, 6, pm, dm);
    n_cmp++; if (pm[5:0] !== 6'b000001) begin
      n_err++; $display("FAIL basic_pulses got=%b exp=000001", pm[5:0]); end
    n_cmp++; if (match_count !== 8'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL basic_count got=%0d busy=%b exp=1 busy=1", match_count, busy); end
    tick();
    n_cmp++; if (match !== 1'b0) begin
      n_err++; $display("FAIL basic_pulse_width got=%b exp=0", match); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_overlap();
    logic [15:0] pm, dm;
    configure(8'b00000101, 4'd3, 8'd0, 1'b1);
    arm();
    feed(16'b10101, 5, pm, dm);
    n_cmp++; if (pm[4:0] !== 5'b00101 || match_count !== 8'd2) begin
      n_err++; $display("FAIL overlap_on got=%b/%0d exp=00101/2", pm[4:0], match_count); end
    abort = 1'b1; tick(); abort = 1'b0;
    configure(8'b00000101, 4'd3, 8'd0, 1'b0);
    arm();
    feed(16'b10101, 5, pm, dm);
    n_cmp++; if (pm[4:0] !== 5'b00100 || match_count !== 8'd1) begin
      n_err++; $display("FAIL overlap_off got=%b/%0d exp=00100/1", pm[4:0], match_count); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_limit();
    logic [15:0] pm, dm;
    configure(8'b00000011, 4'd2, 8'd3, 1'b1);
    arm();
    feed(16'b111111, 6, pm, dm);
    n_cmp++; if (pm[5:0] !== 6'b011100) begin
      n_err++; $display("FAIL limit_pulses got=%b exp=011100", pm[5:0]); end
    n_cmp++; if (dm[5:0] !== 6'b000100) begin
      n_err++; $display("FAIL limit_done got=%b exp=000100", dm[5:0]); end
    n_cmp++; if (match_count !== 8'd3 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL limit_end got=%0d ready=%b busy=%b exp=3 1 0",
                        match_count, cfg_ready, busy); end
  endtask

  task automatic test_gap_abort();
    logic [15:0] pm, dm;
    logic        seen;
    configure(8'b00101011, 4'd6, 8'd0, 1'b1);
    arm();
    feed(16'b101, 3, pm, dm);
    seen = pm[2] | pm[1] | pm[0];
    for (int i = 0; i < 3; i++) begin
      tick(); seen |= match;
    end
    feed(16'b011, 3, pm, dm);
    n_cmp++; if (pm[2:0] !== 3'b001 || seen !== 1'b0) begin
      n_err++; $display("FAIL gap_pulses got=%b early=%b exp=001 early=0", pm[2:0], seen); end
    feed(16'b10101, 5, pm, dm);
    bit_valid = 1'b1; bit_in = 1'b1; abort = 1'b1;
    tick();
    bit_valid = 1'b0; abort = 1'b0;
    n_cmp++; if (match !== 1'b0 || match_count !== 8'd1) begin
      n_err++; $display("FAIL abort_hit got=%b/%0d exp=0/1", match, match_count); end
    n_cmp++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_idle busy=%b ready=%b exp=0 1", busy, cfg_ready); end
    tick();
    n_cmp++; if (match !== 1'b0 || match_count !== 8'd1) begin
      n_err++; $display("FAIL abort_after got=%b/%0d exp=0/1", match, match_count); end
  endtask

  task automatic test_cfg_edges();
    logic [15:0] pm, dm;
    configure(8'b00000001, 4'd0, 8'd0, 1'b1);
    arm();
    feed(16'b1101, 4, pm, dm);
    n_cmp++; if (pm[3:0] !== 4'b1101 || match_count !== 8'd3) begin
      n_err++; $display("FAIL len0 got=%b/%0d exp=1101/3", pm[3:0], match_count); end
    abort = 1'b1; tick(); abort = 1'b0;

    configure(8'b10110011, 4'd15, 8'd0, 1'b1);
    arm();
    feed(16'b10110011, 8, pm, dm);
    n_cmp++; if (pm[7:0] !== 8'b00000001) begin
      n_err++; $display("FAIL len15 got=%b exp=00000001", pm[7:0]); end
    abort = 1'b1; tick(); abort = 1'b0;

    cfg_valid = 1'b1; cfg_pattern = 8'b00000110; cfg_len = 4'd3;
    cfg_max_matches = 8'd0; cfg_overlap = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    feed(16'b110, 3, pm, dm);
    n_cmp++; if (pm[2:0] !== 3'b001 || match_count !== 8'd1) begin
      n_err++; $display("FAIL cfg_start_same got=%b/%0d exp=001/1", pm[2:0], match_count); end

    start = 1'b1; cfg_valid = 1'b1; cfg_pattern = 8'b00000111;
    tick();
    start = 1'b0; cfg_valid = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL scan_ready ready=%b busy=%b exp=0 1", cfg_ready, busy); end
    feed(16'b110, 3, pm, dm);
    n_cmp++; if (pm[2:0] !== 3'b001 || match_count !== 8'd2) begin
      n_err++; $display("FAIL start_in_scan got=%b/%0d exp=001/2", pm[2:0], match_count); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    logic [15:0] pm, dm;
    configure(8'b00101011, 4'd6, 8'd0, 1'b1);
    arm();
    feed(16'b11, 2, pm, dm);
    feed(16'b1010, 4, pm, dm);
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if ({cfg_ready, busy, match, done} !== 4'b1000 || match_count !== 8'd0) begin
      n_err++; $display("FAIL midscan_reset got=%b/%0d exp=1000/0",
                        {cfg_ready, busy, match, done}, match_count); end
    configure(8'b00101011, 4'd6, 8'd0, 1'b1);
    arm();
    feed(16'b101011, 6, pm, dm);
    n_cmp++; if (pm[5:0] !== 6'b000001 || match_count !== 8'd1) begin
      n_err++; $display("FAIL rearm got=%b/%0d exp=000001/1", pm[5:0], match_count); end
  endtask

  initial begin
    test_reset();
    test_reset_config();
    test_basic();
    test_overlap();
    test_limit();
    test_gap_abort();
    test_cfg_edges();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
